// File: rtl/clock_divider_gen_pkg.sv
// Shared definitions for the multi-channel clock divider: channel FSM states,
// minimum divide ratio and the channel-select width helper.
package clock_divider_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } chState_e;

   localparam int DIV_MIN = 2;

   function automatic int chWidth(input int numCh);
      return (numCh > 1) ? $clog2(numCh) : 1;
   endfunction

endpackage

// File: rtl/clock_divider_gen_if.sv
// Control and output bundle of the clock divider; the master drives run requests
// and ratio writes, the slave (the divider) returns clocks, ticks and status.
interface clock_divider_gen_if
   import clock_divider_gen_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 8
);

   localparam int CH_W = chWidth(NUM_CH);

   logic [NUM_CH-1:0] en;
   logic              div_wr;
   logic [CH_W-1:0]   div_ch;
   logic [DIV_W-1:0]  div_val;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] running;

   modport master (
      output en, div_wr, div_ch, div_val,
      input  clk_out, tick, running
   );

   modport slave (
      input  en, div_wr, div_ch, div_val,
      output clk_out, tick, running
   );

endinterface

// File: rtl/clock_divider_gen_channel.sv
// One divided-clock channel: programmable ratio with glitch-free start/stop;
// ratio changes only take effect on a period boundary or while idle.
module clk_div_channel
   import clock_divider_gen_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ld,
   input  logic [DIV_W-1:0] ld_val,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

   chState_e         state_q;
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] activeDiv_q;
   logic [DIV_W-1:0] pendDiv_q;
   logic             clkOut_q;
   logic             tick_q;
   logic             running_q;

   logic [DIV_W-1:0] cntNext_d;
   logic             lastCycle_d;
   logic             highNext_d;

   // High phase is the first D-floor(D/2) counts, so odd ratios favour high.
   always_comb begin
      cntNext_d   = cnt_q + ONE;
      lastCycle_d = (cnt_q == (activeDiv_q - ONE));
      highNext_d  = (cntNext_d < (activeDiv_q - (activeDiv_q >> 1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         activeDiv_q <= RESET_DIV;
         pendDiv_q   <= RESET_DIV;
         clkOut_q    <= 1'b0;
         tick_q      <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         if (ld) begin
            pendDiv_q <= ld_val;
         end
         tick_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               activeDiv_q <= pendDiv_q;
               if (en) begin
                  state_q   <= ST_RUN;
                  cnt_q     <= '0;
                  clkOut_q  <= 1'b1;
                  tick_q    <= 1'b1;
                  running_q <= 1'b1;
               end
            end
            ST_RUN, ST_STOP: begin
               if (lastCycle_d) begin
                  cnt_q       <= '0;
                  activeDiv_q <= pendDiv_q;
                  // A stop request only ends the channel on a completed period.
                  if ((state_q == ST_STOP) && !en) begin
                     state_q   <= ST_IDLE;
                     clkOut_q  <= 1'b0;
                     running_q <= 1'b0;
                  end else begin
                     state_q  <= en ? ST_RUN : ST_STOP;
                     clkOut_q <= 1'b1;
                     tick_q   <= 1'b1;
                  end
               end else begin
                  cnt_q    <= cntNext_d;
                  clkOut_q <= highNext_d;
                  state_q  <= en ? ST_RUN : ST_STOP;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               cnt_q     <= '0;
               clkOut_q  <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign clk_out = clkOut_q;
   assign tick    = tick_q;
   assign running = running_q;

endmodule

// File: rtl/clock_divider_gen.sv
// Multi-channel clock generator top: decodes ratio writes to one channel and
// clamps ratios below the minimum before they reach the channel.
module clock_divider_gen
   import clock_divider_gen_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   clock_divider_gen_if.slave bus
);

   localparam int               CH_W    = chWidth(NUM_CH);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(DIV_MIN);

   logic [DIV_W-1:0]  ldVal;
   logic [NUM_CH-1:0] ldVec;
   logic [NUM_CH-1:0] clkOutVec;
   logic [NUM_CH-1:0] tickVec;
   logic [NUM_CH-1:0] runningVec;

   assign ldVal = (bus.div_val < MIN_DIV) ? MIN_DIV : bus.div_val;

   // Out-of-range channel numbers match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : gCh
      assign ldVec[i] = bus.div_wr && (bus.div_ch == CH_W'(i));

      clk_div_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) uChannel (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (bus.en[i]),
         .ld      (ldVec[i]),
         .ld_val  (ldVal),
         .clk_out (clkOutVec[i]),
         .tick    (tickVec[i]),
         .running (runningVec[i])
      );
   end

   assign bus.clk_out = clkOutVec;
   assign bus.tick    = tickVec;
   assign bus.running = runningVec;

endmodule

// File: tb/tb_clock_divider_gen.sv
// Scoreboard bench for clock_divider_gen: a period-level reference model queues the
// expected outputs for each edge and an independent monitor compares them.
module tb_clock_divider_gen;

   localparam int NUM_CH      = 3;
   localparam int DIV_W       = 8;
   localparam int CH_W        = 2;
   localparam int DEFAULT_DIV = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   clock_divider_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

   clock_divider_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] clkOut;
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] running;
   } expect_t;

   expect_t expQ[$];
   int      checkCount = 0;
   int      passCount  = 0;

   // Reference model: position inside the current period, ratio in use, queued ratio,
   // whether the channel is producing a clock, and the run request seen last edge.
   int mD[NUM_CH];
   int mPend[NUM_CH];
   int mPos[NUM_CH];
   bit mOn[NUM_CH];
   bit mLastEn[NUM_CH];

   task automatic checkOutput(input string name, input logic [NUM_CH-1:0] act,
                              input logic [NUM_CH-1:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic resetModel();
      for (int c = 0; c < NUM_CH; c++) begin
         mD[c]      = DEFAULT_DIV;
         mPend[c]   = DEFAULT_DIV;
         mPos[c]    = 0;
         mOn[c]     = 1'b0;
         mLastEn[c] = 1'b0;
      end
   endtask

   // Drives one cycle of inputs and queues what the outputs must be after the next edge.
   task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic wr,
                                input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] val);
      expect_t e;
      int      newPend;
      bit      tk;
      @(negedge clk);
      bus.en      = en;
      bus.div_wr  = wr;
      bus.div_ch  = ch;
      bus.div_val = val;
      e = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         newPend = mPend[c];
         if (wr && (int'(ch) == c)) begin
            newPend = (int'(val) < 2) ? 2 : int'(val);
         end
         tk = 1'b0;
         if (!mOn[c]) begin
            mD[c] = mPend[c];
            if (en[c]) begin
               mOn[c]  = 1'b1;
               mPos[c] = 0;
               tk      = 1'b1;
            end
         end else if (mPos[c] == mD[c] - 1) begin
            mD[c]   = mPend[c];
            mPos[c] = 0;
            // Stops only when the request was low at both this edge and the previous one.
            if (en[c] || mLastEn[c]) begin
               tk = 1'b1;
            end else begin
               mOn[c] = 1'b0;
            end
         end else begin
            mPos[c] = mPos[c] + 1;
         end
         mLastEn[c] = en[c];
         mPend[c]   = newPend;
         e.clkOut[c]  = mOn[c] && (mPos[c] < (mD[c] + 1) / 2);
         e.tick[c]    = tk;
         e.running[c] = mOn[c];
      end
      expQ.push_back(e);
   endtask

   task automatic runCycles(input logic [NUM_CH-1:0] en, input int n);
      repeat (n) applyStimulus(en, 1'b0, '0, '0);
   endtask

   // Asserts reset shortly after an edge so the drop must be asynchronous.
   task automatic assertReset();
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      bus.en      = '0;
      bus.div_wr  = 1'b0;
      bus.div_ch  = '0;
      bus.div_val = '0;
      #1;
      checkOutput("async rst clk_out", bus.clk_out, '0);
      checkOutput("async rst tick", bus.tick, '0);
      checkOutput("async rst running", bus.running, '0);
      @(posedge clk);
      #1;
      checkOutput("held rst clk_out", bus.clk_out, '0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      resetModel();
   endtask

   initial begin : monitor
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("clk_out", bus.clk_out, e.clkOut);
            checkOutput("tick", bus.tick, e.tick);
            checkOutput("running", bus.running, e.running);
         end
      end
   end

   initial begin : stimulus
      logic [NUM_CH-1:0] enR;
      logic              wrR;
      logic [CH_W-1:0]   chR;
      logic [DIV_W-1:0]  valR;

      bus.en      = '0;
      bus.div_wr  = 1'b0;
      bus.div_ch  = '0;
      bus.div_val = '0;
      resetModel();
      assertReset();

      // Default ratio on channel 0 only.
      runCycles(3'b001, 6);
      runCycles(3'b000, 4);

      // Ratio 5 written while idle, then a mid-period change to 3.
      applyStimulus(3'b000, 1'b1, 2'd0, 8'd5);
      runCycles(3'b001, 11);
      applyStimulus(3'b001, 1'b1, 2'd0, 8'd3);
      runCycles(3'b001, 9);

      // Ratio 4: stop request, then stop and immediate re-raise.
      applyStimulus(3'b001, 1'b1, 2'd0, 8'd4);
      runCycles(3'b001, 7);
      runCycles(3'b000, 8);
      runCycles(3'b001, 4);
      runCycles(3'b000, 3);
      runCycles(3'b001, 6);

      // Reset while channel 0 is high; ratio must fall back to the default.
      assertReset();
      applyStimulus(3'b001, 1'b0, '0, '0);
      assertReset();
      runCycles(3'b001, 6);

      // Ratio 0 is treated as 2; an out-of-range channel write changes nothing.
      applyStimulus(3'b011, 1'b1, 2'd1, 8'd0);
      runCycles(3'b011, 6);
      applyStimulus(3'b011, 1'b1, 2'd3, 8'd9);
      runCycles(3'b111, 12);

      enR = '0;
      for (int i = 0; i < 2500; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 11) == 0) enR[c] = ~enR[c];
         end
         wrR  = ($urandom_range(0, 5) == 0);
         chR  = CH_W'($urandom_range(0, 3));
         valR = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 255))
                                            : DIV_W'($urandom_range(0, 7));
         applyStimulus(enR, wrR, chR, valR);
      end
      runCycles(3'b000, 300);

      @(posedge clk);
      #2;
      checkCount++;
      if (expQ.size() == 0) begin
         passCount++;
      end else begin
         $display("[TB] FAIL scoreboard drain: got %0d entries left expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
